// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM pipeline stage and the data memory.
// The stage holds an access open until ack or timeout; the memory must tolerate abandoned requests.
interface mem_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: EXE/MEM register, data-memory handshake with timeout, MEM/WB register.
// Stalls upstream while an aligned load/store waits for its acknowledge.
module mem_stage #(
   parameter int ACK_TIMEOUT = 255,
   parameter int TCW         = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ewreg,
   input  logic              em2reg,
   input  logic              ewmem,
   input  logic [4:0]        ern,
   input  logic [31:0]       ealu,
   input  logic [31:0]       eb,
   mem_stage_if.master       dmem,
   output logic              mem_stall,
   output logic              wwreg,
   output logic              wm2reg,
   output logic [4:0]        wrn,
   output logic [31:0]       walu,
   output logic [31:0]       wmo,
   output logic              bus_err,
   output logic              align_err
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;

   logic [0:0]     state;
   logic [0:0]     next_state;
   logic [TCW-1:0] count;

   logic           mwreg;
   logic           mm2reg;
   logic           mwmem;
   logic [4:0]     mrn;
   logic [31:0]    malu;
   logic [31:0]    mb;

   logic           e_aligned_mop;
   logic           mop;
   logic           misalign;
   logic           waiting;
   logic           timeout;
   logic           acked;

   assign e_aligned_mop = (em2reg | ewmem) && (ealu[1:0] == 2'b00);
   assign mop           = mm2reg | mwmem;
   assign misalign      = mop && (malu[1:0] != 2'b00);
   assign waiting       = (state == WAIT);
   assign timeout       = waiting && (count == TCW'(ACK_TIMEOUT - 1)) && !dmem.dmem_ack;
   assign acked         = waiting && dmem.dmem_ack;
   assign mem_stall     = waiting && !dmem.dmem_ack && !timeout;

   assign dmem.dmem_req   = waiting;
   assign dmem.dmem_we    = mwmem;
   assign dmem.dmem_addr  = malu;
   assign dmem.dmem_wdata = mb;

   // Whenever M is free to load, the incoming instruction alone decides whether we wait next,
   // which gives back-to-back accesses without an idle cycle.
   always_comb begin
      next_state = IDLE;
      if (mem_stall) begin
         next_state = WAIT;
      end else if (e_aligned_mop) begin
         next_state = WAIT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= next_state;
         if (mem_stall) begin
            count <= count + 1'b1;
         end else begin
            count <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mwreg  <= 1'b0;
         mm2reg <= 1'b0;
         mwmem  <= 1'b0;
         mrn    <= '0;
         malu   <= '0;
         mb     <= '0;
      end else if (!mem_stall) begin
         mwreg  <= ewreg;
         mm2reg <= em2reg;
         mwmem  <= ewmem;
         mrn    <= ern;
         malu   <= ealu;
         mb     <= eb;
      end
   end

   // Misaligned and timed-out loads still retire into W but must never write the register file.
   always_ff @(posedge clk) begin
      if (rst) begin
         wwreg  <= 1'b0;
         wm2reg <= 1'b0;
         wrn    <= '0;
         walu   <= '0;
         wmo    <= '0;
      end else if (mem_stall) begin
         wwreg  <= 1'b0;
         wm2reg <= 1'b0;
      end else begin
         wwreg  <= mwreg && !misalign && !(timeout && mm2reg);
         wm2reg <= mm2reg && !misalign;
         wrn    <= mrn;
         walu   <= malu;
         if (timeout) begin
            wmo <= '0;
         end else if (acked && mm2reg) begin
            wmo <= dmem.dmem_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus_err   <= 1'b0;
         align_err <= 1'b0;
      end else begin
         if (timeout) begin
            bus_err <= 1'b1;
         end
         if (misalign) begin
            align_err <= 1'b1;
         end
      end
   end

endmodule
